// File: rtl/decode_stage.sv
// decode_stage: circular instruction queue feeding a registered RV32/RV64 decoder.
// Optional feature: define DECODE_MULDIV_EN to decode M-extension ops in OP/OP-32;
// without it those encodings decode as illegal.
module decode_stage #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_instr,
  input  logic [XLEN-1:0]         in_pc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_pc,
  output logic [4:0]              out_rd,
  output logic [4:0]              out_rs1,
  output logic [4:0]              out_rs2,
  output logic [XLEN-1:0]         out_imm,
  output logic [7:0]              out_alu_op,
  output logic [2:0]              out_class,
  output logic                    out_reg_write,
  output logic                    out_illegal,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic RV64 = (XLEN == 64);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP32   = 7'b0111011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic [7:0]      alu_op;
    logic [2:0]      cls;
    logic            reg_write;
    logic            illegal;
  } dec_t;

  // Pure combinational decode of one 32-bit instruction word.
  function automatic dec_t decode_instr(input logic [31:0] ins);
    dec_t        d;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] imm_s;
    logic [63:0] imm_i;
    logic [63:0] imm_st;
    logic [63:0] imm_b;
    logic [63:0] imm_u;
    logic [63:0] imm_j;
    logic [63:0] shamt;
    logic        ok;
    logic        is_word;
    logic        is_md;
    logic        alt;
    logic        rw;
    logic [2:0]  cls;
    logic [7:0]  alu;

    opc     = ins[6:0];
    f3      = ins[14:12];
    f7      = ins[31:25];
    imm_i   = {{52{ins[31]}}, ins[31:20]};
    imm_st  = {{52{ins[31]}}, ins[31:25], ins[11:7]};
    imm_b   = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    imm_u   = {{32{ins[31]}}, ins[31:12], 12'h000};
    imm_j   = {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    ok      = 1'b0;
    is_word = 1'b0;
    is_md   = 1'b0;
    alt     = 1'b0;
    rw      = 1'b0;
    cls     = 3'd7;
    alu     = 8'h00;
    imm_s   = 64'd0;
    shamt   = 64'd0;

    case (opc)
      OPC_OP, OPC_OP32: begin
        is_word = (opc == OPC_OP32);
        cls     = 3'd0;
        rw      = 1'b1;
        if (f7 == 7'b0000000) begin
          ok = !is_word || (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b101);
        end else if (f7 == 7'b0100000) begin
          ok  = (f3 == 3'b000) || (f3 == 3'b101);
          alt = ins[30];
        end else if (f7 == 7'b0000001) begin
`ifdef DECODE_MULDIV_EN
          is_md = 1'b1;
          ok    = !is_word || (f3 == 3'b000) || f3[2];
`else
          ok = 1'b0;
`endif
        end else begin
          ok = 1'b0;
        end
        if (is_word && !RV64) begin
          ok = 1'b0;
        end else begin
          ok = ok;
        end
        alu = {1'b0, is_word, is_md, alt, 1'b0, f3};
      end
      OPC_OPIMM, OPC_OPIMM32: begin
        is_word = (opc == OPC_OPIMM32);
        cls     = 3'd1;
        rw      = 1'b1;
        imm_s   = imm_i;
        // Shift amount is 6 bits only for full-width RV64 shifts.
        if (RV64 && !is_word) begin
          shamt = {58'd0, ins[25:20]};
        end else begin
          shamt = {59'd0, ins[24:20]};
        end
        case (f3)
          3'b001: begin
            imm_s = shamt;
            if (is_word) begin
              ok = (f7 == 7'b0000000);
            end else begin
              ok = (ins[31:26] == 6'b000000) && (RV64 || !ins[25]);
            end
          end
          3'b101: begin
            imm_s = shamt;
            alt   = ins[30];
            if (is_word) begin
              ok = (f7 == 7'b0000000) || (f7 == 7'b0100000);
            end else begin
              ok = ((ins[31:26] == 6'b000000) || (ins[31:26] == 6'b010000)) && (RV64 || !ins[25]);
            end
          end
          default: ok = !is_word || (f3 == 3'b000);
        endcase
        if (is_word && !RV64) begin
          ok = 1'b0;
        end else begin
          ok = ok;
        end
        alu = {1'b0, is_word, 1'b0, alt, 1'b0, f3};
      end
      OPC_LOAD: begin
        cls   = 3'd2;
        rw    = 1'b1;
        imm_s = imm_i;
        case (f3)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ok = 1'b1;
          3'b011, 3'b110:                         ok = RV64;
          default:                                ok = 1'b0;
        endcase
      end
      OPC_STORE: begin
        cls   = 3'd3;
        imm_s = imm_st;
        ok    = (f3 <= 3'b010) || ((f3 == 3'b011) && RV64);
      end
      OPC_BRANCH: begin
        cls   = 3'd4;
        alu   = 8'h10;
        imm_s = imm_b;
        ok    = (f3[2:1] != 2'b01);
      end
      OPC_JAL: begin
        cls   = 3'd5;
        rw    = 1'b1;
        imm_s = imm_j;
        ok    = 1'b1;
      end
      OPC_JALR: begin
        cls   = 3'd5;
        rw    = 1'b1;
        imm_s = imm_i;
        ok    = (f3 == 3'b000);
      end
      OPC_LUI, OPC_AUIPC: begin
        cls   = 3'd6;
        rw    = 1'b1;
        imm_s = imm_u;
        ok    = 1'b1;
      end
      default: ok = 1'b0;
    endcase

    d.rd  = ins[11:7];
    d.rs1 = ins[19:15];
    d.rs2 = ins[24:20];
    if (ok) begin
      d.alu_op    = alu;
      d.cls       = cls;
      d.reg_write = rw && (ins[11:7] != 5'd0);
      d.illegal   = 1'b0;
      d.imm       = imm_s[XLEN-1:0];
    end else begin
      d.alu_op    = 8'hFF;
      d.cls       = 3'd7;
      d.reg_write = 1'b0;
      d.illegal   = 1'b1;
      d.imm       = '0;
    end
    return d;
  endfunction

  logic [XLEN+31:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_next_s;
  logic             in_ready_r;
  logic             push_s;
  logic             load_s;
  dec_t             dec_s;
  logic [XLEN-1:0]  head_pc_s;

  logic             out_valid_r;
  logic [XLEN-1:0]  out_pc_r;
  dec_t             out_dec_r;

  // Handshake qualification and next occupancy; flush suppresses both sides.
  always_comb begin
    push_s       = 1'b0;
    load_s       = 1'b0;
    count_next_s = count_r;
    if (flush) begin
      count_next_s = '0;
    end else begin
      push_s       = in_valid && in_ready_r;
      load_s       = (count_r != '0) && (!out_valid_r || out_ready);
      count_next_s = count_r + CW'(push_s) - CW'(load_s);
    end
  end

  // Decode the queue head so the output register can load it directly.
  always_comb begin
    dec_s     = decode_instr(mem_r[rd_ptr_r][31:0]);
    head_pc_s = mem_r[rd_ptr_r][XLEN+31:32];
  end

  // Queue storage: raw {pc, instr} words written at the write pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= {in_pc, in_instr};
    end
  end

  // Pointers, occupancy and the registered in_ready flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      in_ready_r <= 1'b0;
    end else if (flush) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      in_ready_r <= 1'b1;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (load_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      count_r    <= count_next_s;
      in_ready_r <= (count_next_s < CW'(DEPTH));
    end
  end

  // Decode output register; holds its contents while stalled by out_ready.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_r <= 1'b0;
      out_pc_r    <= '0;
      out_dec_r   <= '{rd: 5'd0, rs1: 5'd0, rs2: 5'd0, imm: '0, alu_op: 8'hFF,
                       cls: 3'd0, reg_write: 1'b0, illegal: 1'b0};
    end else if (flush) begin
      out_valid_r <= 1'b0;
    end else if (load_s) begin
      out_valid_r <= 1'b1;
      out_pc_r    <= head_pc_s;
      out_dec_r   <= dec_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign in_ready      = in_ready_r;
  assign count         = count_r;
  assign out_valid     = out_valid_r;
  assign out_pc        = out_pc_r;
  assign out_rd        = out_dec_r.rd;
  assign out_rs1       = out_dec_r.rs1;
  assign out_rs2       = out_dec_r.rs2;
  assign out_imm       = out_dec_r.imm;
  assign out_alu_op    = out_dec_r.alu_op;
  assign out_class     = out_dec_r.cls;
  assign out_reg_write = out_dec_r.reg_write;
  assign out_illegal   = out_dec_r.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: an RV64 instance is fully checked and an
// RV32 instance on the same stimulus checks the XLEN=32 illegal encodings.
module tb_decode_stage;

  logic        clk;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [63:0] in_pc;
  logic        out_ready;

  logic        in_ready;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [4:0]  out_rd;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [63:0] out_imm;
  logic [7:0]  out_alu_op;
  logic [2:0]  out_class;
  logic        out_reg_write;
  logic        out_illegal;
  logic [2:0]  count;

  logic        o32_in_ready;
  logic        o32_valid;
  logic [31:0] o32_pc;
  logic [4:0]  o32_rd;
  logic [4:0]  o32_rs1;
  logic [4:0]  o32_rs2;
  logic [31:0] o32_imm;
  logic [7:0]  o32_alu_op;
  logic [2:0]  o32_class;
  logic        o32_reg_write;
  logic        o32_illegal;
  logic [2:0]  o32_count;

  decode_stage #(.XLEN(64), .DEPTH(4)) u_dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
    .out_alu_op(out_alu_op), .out_class(out_class), .out_reg_write(out_reg_write),
    .out_illegal(out_illegal), .count(count)
  );

  decode_stage #(.XLEN(32), .DEPTH(4)) u_dut32 (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(o32_in_ready), .in_instr(in_instr), .in_pc(in_pc[31:0]),
    .out_valid(o32_valid), .out_ready(out_ready), .out_pc(o32_pc),
    .out_rd(o32_rd), .out_rs1(o32_rs1), .out_rs2(o32_rs2), .out_imm(o32_imm),
    .out_alu_op(o32_alu_op), .out_class(o32_class), .out_reg_write(o32_reg_write),
    .out_illegal(o32_illegal), .count(o32_count)
  );

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [2:0]  regm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        ci;
    logic [63:0] imm;
    logic [7:0]  alu;
    logic [2:0]  cls;
    logic        rw;
    logic        ill;
    logic        ill32;
  } exp_t;

  exp_t        tbl [12];
  exp_t        sb_q [$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  logic [63:0] next_pc  = 64'h1000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic exp_t mk(input logic [31:0] ins, input logic [2:0] regm,
                              input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic ci, input logic [63:0] imm, input logic [7:0] alu,
                              input logic [2:0] cls, input logic rw, input logic ill,
                              input logic ill32);
    exp_t e;
    e.instr = ins; e.pc = 64'd0; e.regm = regm; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
    e.ci = ci; e.imm = imm; e.alu = alu; e.cls = cls; e.rw = rw; e.ill = ill; e.ill32 = ill32;
    return e;
  endfunction

  // Output monitor: every execute-side transfer is matched against the scoreboard.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      check_val("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        check_val("pc", out_pc, mon_e.pc);
        check_val("illegal", 64'(out_illegal), 64'(mon_e.ill));
        check_val("class", 64'(out_class), 64'(mon_e.cls));
        check_val("alu_op", 64'(out_alu_op), 64'(mon_e.alu));
        check_val("reg_write", 64'(out_reg_write), 64'(mon_e.rw));
        if (mon_e.regm[2]) check_val("rd", 64'(out_rd), 64'(mon_e.rd));
        if (mon_e.regm[1]) check_val("rs1", 64'(out_rs1), 64'(mon_e.rs1));
        if (mon_e.regm[0]) check_val("rs2", 64'(out_rs2), 64'(mon_e.rs2));
        if (mon_e.ci) check_val("imm", out_imm, mon_e.imm);
        check_val("valid32", 64'(o32_valid), 64'd1);
        check_val("pc32", 64'(o32_pc), 64'(mon_e.pc[31:0]));
        check_val("illegal32", 64'(o32_illegal), 64'(mon_e.ill32));
        check_val("alu_op32", 64'(o32_alu_op), mon_e.ill32 ? 64'hFF : 64'(mon_e.alu));
      end
    end
  end

  task automatic push_idx(input int idx);
    exp_t e;
    int   waits;
    e = tbl[idx];
    e.pc = next_pc;
    next_pc = next_pc + 64'd4;
    in_valid = 1'b1;
    in_instr = e.instr;
    in_pc    = e.pc;
    waits    = 0;
    @(negedge clk);
    while (!in_ready && waits < 40) begin
      waits++;
      @(negedge clk);
    end
    if (waits >= 40) check_val("push_timeout", 64'(waits), 64'd0);
    else sb_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    check_val("drain", 64'(sb_q.size()), 64'd0);
  endtask

  task automatic check_reset_outs(input string tag);
    check_val({tag, "_count"}, 64'(count), 64'd0);
    check_val({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check_val({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    check_val({tag, "_alu_op"}, 64'(out_alu_op), 64'hFF);
    check_val({tag, "_imm"}, out_imm, 64'd0);
    check_val({tag, "_rd"}, 64'(out_rd), 64'd0);
    check_val({tag, "_class"}, 64'(out_class), 64'd0);
    check_val({tag, "_illegal"}, 64'(out_illegal), 64'd0);
    check_val({tag, "_alu_op32"}, 64'(o32_alu_op), 64'hFF);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] pc_first;
    int          c0;

    tbl[0]  = mk(32'h002081B3, 3'b111, 5'd3, 5'd1, 5'd2, 1'b0, 64'd0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0);
    tbl[1]  = mk(32'hFFF00293, 3'b110, 5'd5, 5'd0, 5'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 3'd1, 1'b1, 1'b0, 1'b0);
    tbl[2]  = mk(32'h00208463, 3'b011, 5'd0, 5'd1, 5'd2, 1'b1, 64'd8, 8'h10, 3'd4, 1'b0, 1'b0, 1'b0);
`ifdef DECODE_MULDIV_EN
    tbl[3]  = mk(32'h022081B3, 3'b111, 5'd3, 5'd1, 5'd2, 1'b0, 64'd0, 8'h20, 3'd0, 1'b1, 1'b0, 1'b0);
`else
    tbl[3]  = mk(32'h022081B3, 3'b000, 5'd0, 5'd0, 5'd0, 1'b0, 64'd0, 8'hFF, 3'd7, 1'b0, 1'b1, 1'b1);
`endif
    tbl[4]  = mk(32'h002081BB, 3'b111, 5'd3, 5'd1, 5'd2, 1'b0, 64'd0, 8'h40, 3'd0, 1'b1, 1'b0, 1'b1);
    tbl[5]  = mk(32'h402081B3, 3'b111, 5'd3, 5'd1, 5'd2, 1'b0, 64'd0, 8'h10, 3'd0, 1'b1, 1'b0, 1'b0);
    tbl[6]  = mk(32'h4212D293, 3'b110, 5'd5, 5'd5, 5'd0, 1'b1, 64'd33, 8'h15, 3'd1, 1'b1, 1'b0, 1'b1);
    tbl[7]  = mk(32'h00813303, 3'b110, 5'd6, 5'd2, 5'd0, 1'b1, 64'd8, 8'h00, 3'd2, 1'b1, 1'b0, 1'b1);
    tbl[8]  = mk(32'h800003B7, 3'b100, 5'd7, 5'd0, 5'd0, 1'b1, 64'hFFFF_FFFF_8000_0000, 8'h00, 3'd6, 1'b1, 1'b0, 1'b0);
    tbl[9]  = mk(32'hFFDFF06F, 3'b100, 5'd0, 5'd0, 5'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 8'h00, 3'd5, 1'b0, 1'b0, 1'b0);
    tbl[10] = mk(32'h00000000, 3'b000, 5'd0, 5'd0, 5'd0, 1'b0, 64'd0, 8'hFF, 3'd7, 1'b0, 1'b1, 1'b1);
    tbl[11] = mk(32'h0020A463, 3'b000, 5'd0, 5'd0, 5'd0, 1'b0, 64'd0, 8'hFF, 3'd7, 1'b0, 1'b1, 1'b1);

    // Reset state, including after clock edges while held in reset.
    reset_n = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = 32'd0; in_pc = 64'd0; out_ready = 1'b0;
    #2 reset_n = 1'b0;
    #1 check_reset_outs("rst");
    repeat (2) @(posedge clk);
    #1 check_val("rst_hold_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1 check_val("rst_rel_in_ready", 64'(in_ready), 64'd1);
    check_val("rst_rel_count", 64'(count), 64'd0);

    // First instruction latency: accepted at edge N, visible after edge N+1.
    out_ready = 1'b1;
    push_idx(0);
    check_val("lat_edge_n", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1 check_val("lat_edge_n1", 64'(out_valid), 64'd1);
    wait_drain();

    // Back-to-back stream of every pattern: one accept per cycle.
    c0 = cyc;
    for (int i = 0; i < 12; i++) push_idx(i);
    check_val("throughput_cycles", 64'(cyc - c0), 64'd12);
    wait_drain();

    // Backpressure: five pushes fill decode register plus four queue entries.
    out_ready = 1'b0;
    pc_first = next_pc;
    push_idx(0); push_idx(5); push_idx(4); push_idx(2); push_idx(8);
    check_val("full_count", 64'(count), 64'd4);
    check_val("full_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 64'hFFF0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_val("full_stall_ready", 64'(in_ready), 64'd0);
      check_val("full_stall_valid", 64'(out_valid), 64'd1);
      check_val("full_stall_pc", out_pc, pc_first);
      check_val("full_stall_count", 64'(count), 64'd4);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain();

    // Flush with three queued entries and a same-cycle push.
    out_ready = 1'b0;
    push_idx(1); push_idx(6); push_idx(7); push_idx(9);
    check_val("pre_flush_count", 64'(count), 64'd3);
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 64'hDEAD0;
    @(posedge clk);
    #1 flush = 1'b0; in_valid = 1'b0;
    check_val("flush_count", 64'(count), 64'd0);
    check_val("flush_out_valid", 64'(out_valid), 64'd0);
    check_val("flush_in_ready", 64'(in_ready), 64'd1);
    sb_q.delete();
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1 check_val("flush_quiet", 64'(out_valid), 64'd0);
    push_idx(8);
    wait_drain();

    // Asynchronous reset mid-stream, between clock edges.
    out_ready = 1'b0;
    push_idx(0); push_idx(3); push_idx(6);
    #2 reset_n = 1'b0;
    #1 check_reset_outs("async_rst");
    sb_q.delete();
    @(negedge clk) reset_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1 check_val("post_rst_in_ready", 64'(in_ready), 64'd1);
    check_val("post_rst_count", 64'(count), 64'd0);
    push_idx(2); push_idx(4);
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
